alu_fx_pipe: RTL and testbench

ALU_FX_PIPE -- requirements
Module: alu_fx_pipe

---
 rtl/alu_fx_pkg.sv | 36 +++
 rtl/alu_fx_pipe_if.sv | 29 ++
 rtl/fx_div_iter.sv | 61 ++++++
 rtl/alu_fx_pipe.sv | 170 +++++++++++++++++
 tb/tb_alu_fx_pipe.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_fx_pkg.sv
// Shared types and saturation limits for the fixed-point ALU pipe.
package alu_fx_pkg;

  typedef enum logic [3:0] {
    OpAdd   = 4'b0000,
    OpAnd   = 4'b0001,
    OpOr    = 4'b0010,
    OpNotA  = 4'b0011,
    OpMul   = 4'b0100,
    OpDiv   = 4'b0101,
    OpAddi  = 4'b0110,
    OpSub   = 4'b1001,
    OpPassA = 4'b1011
  } opcode_e;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StHold} state_e;

  localparam int unsigned MaxW = 64;

  // Largest positive n-bit two's-complement value, zero-extended to MaxW.
  function automatic logic [MaxW-1:0] sat_max(input int unsigned n);
    logic [MaxW-1:0] v;
    v = {MaxW{1'b1}};
    v = v >> (MaxW - n + 1);
    return v;
  endfunction

  // Most negative n-bit two's-complement value, zero-extended to MaxW.
  function automatic logic [MaxW-1:0] sat_min(input int unsigned n);
    logic [MaxW-1:0] v;
    v = {{(MaxW-1){1'b0}}, 1'b1};
    v = v << (n - 1);
    return v;
  endfunction

endpackage

// File: rtl/alu_fx_pipe_if.sv
// Request/response bundle between an ALU client and alu_fx_pipe.
interface alu_fx_pipe_if #(
  parameter int unsigned N            = 32,
  parameter int unsigned WIDTH_OPCODE = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH_OPCODE-1:0] opcode;
  logic [N-1:0]            dataA;
  logic [N-1:0]            dataB;
  logic [N-1:0]            data_imm;
  logic                    out_valid;
  logic                    out_ready;
  logic [N-1:0]            data_out;
  logic                    zero;
  logic                    ovf;
  logic                    dz;
  logic                    illegal;

  modport master (
    output in_valid, opcode, dataA, dataB, data_imm, out_ready,
    input  in_ready, out_valid, data_out, zero, ovf, dz, illegal
  );

  modport slave (
    input  in_valid, opcode, dataA, dataB, data_imm, out_ready,
    output in_ready, out_valid, data_out, zero, ovf, dz, illegal
  );
endinterface

// File: rtl/fx_div_iter.sv
// Restoring divider on unsigned magnitudes, one quotient bit per cycle, N+Q iterations.
module fx_div_iter #(
  parameter int unsigned N = 32,
  parameter int unsigned Q = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic [N+Q-1:0] dividend_i,
  input  logic [N-1:0]   divisor_i,
  output logic           done_o,
  output logic [N+Q-1:0] quotient_o
);
  localparam int unsigned W    = N + Q;
  localparam int unsigned CntW = $clog2(W + 1);

  logic            busy_q, done_q;
  logic [CntW-1:0] cnt_q;
  logic [W-1:0]    dvd_q;
  logic [N-1:0]    rem_q, dsr_q;
  logic [N:0]      rem_sh, rem_sub;
  logic            ge;

  always_comb begin
    rem_sh  = {rem_q, dvd_q[W-1]};
    rem_sub = rem_sh - {1'b0, dsr_q};
    ge      = rem_sh >= {1'b0, dsr_q};
  end

  // Quotient bits shift into the dividend register as dividend bits shift out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      dvd_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        busy_q <= 1'b1;
        cnt_q  <= CntW'(W);
        dvd_q  <= dividend_i;
        rem_q  <= '0;
        dsr_q  <= divisor_i;
      end else if (busy_q) begin
        rem_q <= ge ? N'(rem_sub) : N'(rem_sh);
        dvd_q <= {dvd_q[W-2:0], ge};
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o     = done_q;
  assign quotient_o = dvd_q;
endmodule

// File: rtl/alu_fx_pipe.sv
// Signed Q-format ALU with pipelined multiply, iterative divide and a valid/ready result hold.
module alu_fx_pipe
  import alu_fx_pkg::*;
#(
  parameter int unsigned N            = 32,
  parameter int unsigned Q            = 16,
  parameter int unsigned WIDTH_OPCODE = 4,
  parameter int unsigned MUL_STAGES   = 2,
  parameter int unsigned SAT_EN       = 1
) (
  input logic          clk,
  input logic          rstn,
  alu_fx_pipe_if.slave bus
);
  localparam int unsigned W      = N + Q;
  localparam int unsigned W2     = 2 * N;
  localparam logic [N-1:0] SatMax = N'(sat_max(N));
  localparam logic [N-1:0] SatMin = N'(sat_min(N));
  localparam logic [W-1:0] DivLim = W'(SatMin);

  state_e                   state_q;
  logic                     out_valid_q, zero_q, ovf_q, dz_q, ill_q, div_neg_q;
  logic [N-1:0]             data_q, a_q, b_q, imm_q;
  logic [WIDTH_OPCODE-1:0]  op_q;
  logic [MUL_STAGES-1:0]    mul_vld_q;
  logic signed [W2-1:0]     mul_pipe_q [MUL_STAGES];

  logic                 accept, mul_start, div_start, div_done, load_out;
  logic [N-1:0]         abs_a, abs_b, cand_raw, fin_data;
  logic [W-1:0]         div_dvd, div_quot, div_sq;
  logic [N:0]           add_r, addi_r, sub_r;
  logic signed [W2-1:0] mul_p, mul_sh;
  logic                 cand_ovf, cand_neg, cand_dz, cand_ill;

  always_comb begin
    accept    = bus.in_valid && (state_q == StIdle);
    mul_start = accept && (bus.opcode == WIDTH_OPCODE'(OpMul));
    div_start = accept && (bus.opcode == WIDTH_OPCODE'(OpDiv)) && (bus.dataB != '0);
    abs_a     = bus.dataA[N-1] ? -bus.dataA : bus.dataA;
    abs_b     = bus.dataB[N-1] ? -bus.dataB : bus.dataB;
    div_dvd   = W'(abs_a) << Q;
  end

  fx_div_iter #(
    .N (N),
    .Q (Q)
  ) u_div (
    .clk_i      (clk),
    .rst_ni     (rstn),
    .start_i    (div_start),
    .dividend_i (div_dvd),
    .divisor_i  (abs_b),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  always_comb begin
    add_r    = {a_q[N-1], a_q} + {b_q[N-1], b_q};
    addi_r   = {a_q[N-1], a_q} + {imm_q[N-1], imm_q};
    sub_r    = {a_q[N-1], a_q} - {b_q[N-1], b_q};
    mul_p    = mul_pipe_q[MUL_STAGES-1];
    mul_sh   = mul_p >>> Q;
    div_sq   = div_neg_q ? -div_quot : div_quot;
    cand_raw = '0;
    cand_ovf = 1'b0;
    cand_neg = 1'b0;
    cand_dz  = 1'b0;
    cand_ill = 1'b0;
    if (state_q == StMul) begin
      cand_raw = N'(mul_sh);
      cand_ovf = mul_sh != W2'($signed(cand_raw));
      cand_neg = mul_p[W2-1];
    end else if (state_q == StDiv) begin
      cand_raw = N'(div_sq);
      cand_ovf = div_neg_q ? (div_quot > DivLim) : (div_quot >= DivLim);
      cand_neg = div_neg_q;
    end else begin
      case (op_q)
        WIDTH_OPCODE'(OpAdd): begin
          cand_raw = add_r[N-1:0];
          cand_ovf = add_r[N] ^ add_r[N-1];
          cand_neg = add_r[N];
        end
        WIDTH_OPCODE'(OpAddi): begin
          cand_raw = addi_r[N-1:0];
          cand_ovf = addi_r[N] ^ addi_r[N-1];
          cand_neg = addi_r[N];
        end
        WIDTH_OPCODE'(OpSub): begin
          cand_raw = sub_r[N-1:0];
          cand_ovf = sub_r[N] ^ sub_r[N-1];
          cand_neg = sub_r[N];
        end
        WIDTH_OPCODE'(OpAnd):   cand_raw = a_q & b_q;
        WIDTH_OPCODE'(OpOr):    cand_raw = a_q | b_q;
        WIDTH_OPCODE'(OpNotA):  cand_raw = ~a_q;
        WIDTH_OPCODE'(OpPassA): cand_raw = a_q;
        // A divide only lands here when the divisor was zero.
        WIDTH_OPCODE'(OpDiv): begin
          cand_dz  = 1'b1;
          cand_raw = (a_q == '0) ? '0 : (a_q[N-1] ? SatMin : SatMax);
        end
        default: cand_ill = 1'b1;
      endcase
    end
    fin_data = (cand_ovf && (SAT_EN != 0)) ? (cand_neg ? SatMin : SatMax) : cand_raw;
    load_out = ((state_q == StMul) && mul_vld_q[MUL_STAGES-1]) ||
               ((state_q == StDiv) && div_done) ||
               ((state_q == StHold) && !out_valid_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      ill_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      op_q        <= '0;
      div_neg_q   <= 1'b0;
      mul_vld_q   <= '0;
      for (int i = 0; i < MUL_STAGES; i++) mul_pipe_q[i] <= '0;
    end else begin
      mul_vld_q[0] <= mul_start;
      for (int i = 1; i < MUL_STAGES; i++) begin
        mul_vld_q[i]  <= mul_vld_q[i-1];
        mul_pipe_q[i] <= mul_pipe_q[i-1];
      end
      if (mul_start) mul_pipe_q[0] <= $signed(bus.dataA) * $signed(bus.dataB);
      if (load_out) begin
        out_valid_q <= 1'b1;
        data_q      <= fin_data;
        zero_q      <= (fin_data == '0);
        ovf_q       <= cand_ovf;
        dz_q        <= cand_dz;
        ill_q       <= cand_ill;
      end
      case (state_q)
        StIdle: if (accept) begin
          a_q       <= bus.dataA;
          b_q       <= bus.dataB;
          imm_q     <= bus.data_imm;
          op_q      <= bus.opcode;
          div_neg_q <= bus.dataA[N-1] ^ bus.dataB[N-1];
          state_q   <= mul_start ? StMul : (div_start ? StDiv : StHold);
        end
        StMul:  if (mul_vld_q[MUL_STAGES-1]) state_q <= StHold;
        StDiv:  if (div_done) state_q <= StHold;
        StHold: if (out_valid_q && bus.out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.dz        = dz_q;
  assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_fx_pipe.sv
// Directed bench for alu_fx_pipe: saturating and wrapping instances share one stimulus stream.
module tb_alu_fx_pipe;
  typedef struct packed {
    logic [31:0] data;
    logic        zero;
    logic        ovf;
    logic        dz;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_s[$];
  exp_t sb_w[$];

  always #5 clk = ~clk;

  alu_fx_pipe_if #(.N(32), .WIDTH_OPCODE(4)) bus ();
  alu_fx_pipe_if #(.N(32), .WIDTH_OPCODE(4)) bus_w ();

  assign bus_w.in_valid  = bus.in_valid;
  assign bus_w.opcode    = bus.opcode;
  assign bus_w.dataA     = bus.dataA;
  assign bus_w.dataB     = bus.dataB;
  assign bus_w.data_imm  = bus.data_imm;
  assign bus_w.out_ready = bus.out_ready;

  alu_fx_pipe #(.N(32), .Q(16), .WIDTH_OPCODE(4), .MUL_STAGES(2), .SAT_EN(1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  alu_fx_pipe #(.N(32), .Q(16), .WIDTH_OPCODE(4), .MUL_STAGES(2), .SAT_EN(0)) dut_w (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_w)
  );

  // Reference model in 64-bit integer arithmetic, Q16 operands.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, b, imm,
                                 input bit sat);
    exp_t   e;
    longint sa, sb, si, r, hi, lo;
    bit     arith;
    sa = $signed(a);
    sb = $signed(b);
    si = $signed(imm);
    hi = (longint'(1) <<< 31) - 1;
    lo = -(longint'(1) <<< 31);
    e = '0;
    r = 0;
    arith = 1'b1;
    case (op)
      4'h0: r = sa + sb;
      4'h9: r = sa - sb;
      4'h6: r = sa + si;
      4'h4: r = (sa * sb) >>> 16;
      4'h5: if (b == 32'h0) begin
        arith = 1'b0;
        e.dz = 1'b1;
        e.data = (sa > 0) ? 32'h7fff_ffff : ((sa < 0) ? 32'h8000_0000 : 32'h0);
      end else begin
        r = (sa * 65536) / sb;
      end
      4'h1: begin arith = 1'b0; e.data = a & b; end
      4'h2: begin arith = 1'b0; e.data = a | b; end
      4'h3: begin arith = 1'b0; e.data = ~a; end
      4'hb: begin arith = 1'b0; e.data = a; end
      default: begin arith = 1'b0; e.ill = 1'b1; e.data = 32'h0; end
    endcase
    if (arith) begin
      e.ovf  = (r > hi) || (r < lo);
      e.data = (e.ovf && sat) ? ((r < 0) ? 32'h8000_0000 : 32'h7fff_ffff) : r[31:0];
    end
    e.zero = (e.data == 32'h0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input exp_t es, input exp_t ew);
    chk("out_valid", bus.out_valid, 1);
    chk("data_sat", bus.data_out, es.data);
    chk("zero", bus.zero, es.zero);
    chk("ovf", bus.ovf, es.ovf);
    chk("dz", bus.dz, es.dz);
    chk("illegal", bus.illegal, es.ill);
    chk("data_wrap", bus_w.data_out, ew.data);
    chk("ovf_wrap", bus_w.ovf, ew.ovf);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, b, imm, input int stall);
    exp_t es, ew;
    int   cyc, lat;
    lat = (op == 4'h4) ? 2 : (((op == 4'h5) && (b != 32'h0)) ? 49 : 1);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.opcode   = op;
    bus.dataA    = a;
    bus.dataB    = b;
    bus.data_imm = imm;
    bus.in_valid = 1'b1;
    step();
    sb_s.push_back(model(op, a, b, imm, 1'b1));
    sb_w.push_back(model(op, a, b, imm, 1'b0));
    // Scramble inputs: the captured operands must be used.
    bus.in_valid = 1'b0;
    bus.opcode   = 4'($urandom);
    bus.dataA    = $urandom;
    bus.dataB    = $urandom;
    bus.data_imm = $urandom;
    chk("in_ready_busy", bus.in_ready, 0);
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      step();
      cyc++;
    end
    chk("latency", cyc, lat);
    es = sb_s.pop_front();
    ew = sb_w.pop_front();
    chk_out(es, ew);
    for (int s = 0; s < stall; s++) begin
      step();
      chk_out(es, ew);
      chk("in_ready_stall", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("valid_drop", bus.out_valid, 0);
    chk("in_ready_back", bus.in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops [9];
    int         seen;
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h9, 4'hb};
    bus.in_valid  = 1'b0;
    bus.opcode    = '0;
    bus.dataA     = '0;
    bus.dataB     = '0;
    bus.data_imm  = '0;
    bus.out_ready = 1'b0;

    repeat (3) step();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_zero", bus.zero, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_dz", bus.dz, 0);
    chk("rst_illegal", bus.illegal, 0);
    #2 rstn = 1'b1;
    step();
    chk("rst_release_ready", bus.in_ready, 1);

    do_op(4'h4, 32'h0001_8000, 32'h0002_0000, 32'h0, 0);
    do_op(4'h5, 32'h0003_0000, 32'h0002_0000, 32'h0, 0);
    do_op(4'h5, 32'hFFFD_0000, 32'h0002_0000, 32'h0, 0);
    do_op(4'h0, 32'h7FFF_0000, 32'h0002_0000, 32'h0, 0);
    do_op(4'h5, 32'hFFFF_0000, 32'h0, 32'h0, 0);
    do_op(4'hF, 32'h1234_5678, 32'h1, 32'h0, 0);
    do_op(4'h9, 32'h5, 32'h5, 32'h0, 5);
    do_op(4'h1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 0);
    do_op(4'h2, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0, 1);
    do_op(4'h3, 32'h1234_5678, 32'h0, 32'h0, 0);
    do_op(4'hB, 32'hDEAD_BEEF, 32'h0, 32'h0, 0);
    do_op(4'h6, 32'h0001_0000, 32'h7FFF_FFFF, 32'hFFFF_8000, 0);
    do_op(4'h9, 32'h8000_0000, 32'h1, 32'h0, 0);
    do_op(4'h4, 32'hFFFF_FFFF, 32'h0000_8000, 32'h0, 0);
    do_op(4'h4, 32'h7FFF_0000, 32'h0002_0000, 32'h0, 0);
    do_op(4'h5, 32'h8000_0000, 32'hFFFF_0000, 32'h0, 0);
    do_op(4'h5, 32'h0, 32'h0, 32'h0, 0);
    do_op(4'h7, 32'h5, 32'h6, 32'h7, 0);

    // Abort a divide with an asynchronous reset pulse.
    chk("div_abort_ready", bus.in_ready, 1);
    bus.opcode   = 4'h5;
    bus.dataA    = 32'h0003_0000;
    bus.dataB    = 32'h0002_0000;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (10) step();
    chk("div_busy_ready", bus.in_ready, 0);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_ready", bus.in_ready, 1);
    repeat (2) step();
    #2 rstn = 1'b1;
    step();
    chk("post_abort_ready", bus.in_ready, 1);
    seen = 0;
    repeat (60) begin
      step();
      if (bus.out_valid) seen = 1;
    end
    chk("abort_no_result", seen, 0);

    for (int i = 0; i < 10; i++)
      do_op(ops[$urandom_range(0, 8)], $urandom, $urandom, $urandom, $urandom_range(0, 2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
